// File: rtl/video_mixer_pkg.sv
// Shared register offsets, CTRL bit positions, reset values and the control-field
// struct for the video layer mixer.
package video_mixer_pkg;

  localparam logic [7:0] OFS_CTRL        = 8'd0;
  localparam logic [7:0] OFS_LAYER_EN    = 8'd1;
  localparam logic [7:0] OFS_BACKDROP_LO = 8'd2;
  localparam logic [7:0] OFS_BACKDROP_HI = 8'd3;

  localparam int CTRL_SCANLINE_BIT = 0;
  localparam int CTRL_BG_BIT       = 1;
  localparam int CTRL_DIM_LSB      = 2;
  localparam int CTRL_SCREEN_BIT   = 7;

  localparam logic [7:0]  CTRL_RESET     = 8'h8A;
  localparam logic [7:0]  LAYER_EN_RESET = 8'hFF;
  localparam logic [15:0] BACKDROP_RESET = 16'h0000;

  typedef struct packed {
    logic       screen_en;
    logic [1:0] dim_shift;
    logic       bg_en;
    logic       scanline_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET_FIELDS = '{
    screen_en:   CTRL_RESET[CTRL_SCREEN_BIT],
    dim_shift:   CTRL_RESET[CTRL_DIM_LSB +: 2],
    bg_en:       CTRL_RESET[CTRL_BG_BIT],
    scanline_en: CTRL_RESET[CTRL_SCANLINE_BIT]
  };

endpackage

// File: rtl/video_mixer_io_regs.sv
// I/O strobe capture, address decode and register storage for the video layer mixer.
// A strobe held low is a single write; it re-arms only after io_in is seen high.
module video_mixer_io_regs
  import video_mixer_pkg::*;
#(
  parameter int         NUM_LAYERS = 4,
  parameter int         PW         = 12,
  parameter logic [7:0] IO_BASE    = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_in,
  input  logic [15:0]           io_address_in,
  input  logic [7:0]            io_data_in,
  output logic                  screen_en_o,
  output logic                  bg_en_o,
  output logic                  scanline_en_o,
  output logic [1:0]            dim_shift_o,
  output logic [NUM_LAYERS-1:0] layer_en_o,
  output logic [PW-1:0]         backdrop_o
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
  logic [PW-1:0]         backdrop_q, backdrop_d;
  logic                  ack_q, ack_d;
  logic                  accept;
  logic [7:0]            addr;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^io_address_in[15:8];
  assign addr           = io_address_in[7:0];
  assign accept         = ~io_in & ~ack_q;
  assign ack_d          = ~io_in;

  always_comb begin
    ctrl_d     = ctrl_q;
    layer_en_d = layer_en_q;
    backdrop_d = backdrop_q;
    if (accept) begin
      if (addr == IO_BASE + OFS_CTRL) begin
        ctrl_d.screen_en   = io_data_in[CTRL_SCREEN_BIT];
        ctrl_d.dim_shift   = io_data_in[CTRL_DIM_LSB +: 2];
        ctrl_d.bg_en       = io_data_in[CTRL_BG_BIT];
        ctrl_d.scanline_en = io_data_in[CTRL_SCANLINE_BIT];
      end
      if (addr == IO_BASE + OFS_LAYER_EN) begin
        layer_en_d = io_data_in[NUM_LAYERS-1:0];
      end
      // Backdrop bits above PW simply have no storage, which truncates the value.
      for (int b = 0; b < PW; b++) begin
        if (b < 8) begin
          if (addr == IO_BASE + OFS_BACKDROP_LO) backdrop_d[b] = io_data_in[b[2:0]];
        end else begin
          if (addr == IO_BASE + OFS_BACKDROP_HI) backdrop_d[b] = io_data_in[b[2:0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_RESET_FIELDS;
      layer_en_q <= LAYER_EN_RESET[NUM_LAYERS-1:0];
      backdrop_q <= BACKDROP_RESET[PW-1:0];
      ack_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      layer_en_q <= layer_en_d;
      backdrop_q <= backdrop_d;
      ack_q      <= ack_d;
    end
  end

  assign screen_en_o   = ctrl_q.screen_en;
  assign bg_en_o       = ctrl_q.bg_en;
  assign scanline_en_o = ctrl_q.scanline_en;
  assign dim_shift_o   = ctrl_q.dim_shift;
  assign layer_en_o    = layer_en_q;
  assign backdrop_o    = backdrop_q;

endmodule

// File: rtl/video_layer_mixer.sv
// N-layer priority compositor with backdrop, blanking and scanline dimming (two-stage pipeline).
// Scanline dimming is built only when VIDEO_MIXER_SCANLINE_EN is defined.
module video_layer_mixer
  import video_mixer_pkg::*;
#(
  parameter int         NUM_LAYERS = 4,
  parameter int         CW         = 4,
  parameter int         FG_LAYER   = 1,
  parameter logic [7:0] IO_BASE    = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vga_h_sync,
  input  logic                         vga_v_sync,
  input  logic                         in_display_area,
  input  logic                         counter_y_lsb,
  input  logic [NUM_LAYERS*3*CW-1:0]   layer_data,
  input  logic [NUM_LAYERS-1:0]        layer_active,
  input  logic                         foreground_mask,
  input  logic                         io_in,
  input  logic [15:0]                  io_address_in,
  input  logic [7:0]                   io_data_in,
  output logic [CW-1:0]                vga_r,
  output logic [CW-1:0]                vga_g,
  output logic [CW-1:0]                vga_b,
  output logic                         vga_h_sync_out,
  output logic                         vga_v_sync_out,
  output logic                         vga_de_out
);

  localparam int PW = 3 * CW;

  logic                  screen_en, bg_en, scanline_en;
  logic [1:0]            dim_shift;
  logic [NUM_LAYERS-1:0] layer_en;
  logic [PW-1:0]         backdrop;

  video_mixer_io_regs #(
    .NUM_LAYERS (NUM_LAYERS),
    .PW         (PW),
    .IO_BASE    (IO_BASE)
  ) u_io_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_in         (io_in),
    .io_address_in (io_address_in),
    .io_data_in    (io_data_in),
    .screen_en_o   (screen_en),
    .bg_en_o       (bg_en),
    .scanline_en_o (scanline_en),
    .dim_shift_o   (dim_shift),
    .layer_en_o    (layer_en),
    .backdrop_o    (backdrop)
  );

  logic [PW-1:0] layer_pix [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
    assign layer_pix[gi] = layer_data[gi*PW +: PW];
  end

  logic [NUM_LAYERS-1:0] opaque;
  logic [PW-1:0]         pix_d, pix_q;
  logic                  de_q, hs_q, vs_q, screen_q;

  // Walk from the background upward so the lowest-index opaque layer is written last.
  always_comb begin
    opaque = layer_active & layer_en;
    if (foreground_mask) opaque[FG_LAYER] = 1'b0;
    if (!bg_en) opaque[NUM_LAYERS-1] = 1'b0;
    pix_d = backdrop;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) pix_d = layer_pix[i];
    end
  end

  // Control fields travel with the pixel so a write reaches the outputs exactly 2 cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      screen_q <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      de_q     <= in_display_area;
      hs_q     <= vga_h_sync;
      vs_q     <= vga_v_sync;
      screen_q <= screen_en;
    end
  end

  logic          de_d;
  logic [CW-1:0] r_d, g_d, b_d;

  assign de_d = de_q & screen_q;

`ifdef VIDEO_MIXER_SCANLINE_EN
  logic       line_q, scan_q;
  logic [1:0] dim_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= 1'b0;
      scan_q <= 1'b0;
      dim_q  <= 2'd0;
    end else begin
      line_q <= counter_y_lsb;
      scan_q <= scanline_en;
      dim_q  <= dim_shift;
    end
  end
`else
  logic unused_scanline;
  assign unused_scanline = ^{counter_y_lsb, scanline_en, dim_shift};
`endif

  always_comb begin
    r_d = pix_q[2*CW +: CW];
    g_d = pix_q[CW +: CW];
    b_d = pix_q[0 +: CW];
`ifdef VIDEO_MIXER_SCANLINE_EN
    if (scan_q && !line_q) begin
      r_d = r_d >> dim_q;
      g_d = g_d >> dim_q;
      b_d = b_d >> dim_q;
    end
`endif
    if (!de_d) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r          <= '0;
      vga_g          <= '0;
      vga_b          <= '0;
      vga_h_sync_out <= 1'b0;
      vga_v_sync_out <= 1'b0;
      vga_de_out     <= 1'b0;
    end else begin
      vga_r          <= r_d;
      vga_g          <= g_d;
      vga_b          <= b_d;
      vga_h_sync_out <= hs_q;
      vga_v_sync_out <= vs_q;
      vga_de_out     <= de_d;
    end
  end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer: a per-cycle reference model plus literal checkpoints.
`timescale 1ns/1ps
module tb_video_layer_mixer;

  localparam int NL = 4;
  localparam int CW = 4;
`ifdef VIDEO_MIXER_SCANLINE_EN
  localparam logic [11:0] DIM_EXP = 12'h333;
`else
  localparam logic [11:0] DIM_EXP = 12'hFFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, hs, vs, disp, lsb, fg, io_in;
  logic [15:0]   addr;
  logic [7:0]    data;
  logic [47:0]   ldata;
  logic [3:0]    lact;
  logic [CW-1:0] vr, vg, vb;
  logic          hso, vso, deo;

  video_layer_mixer #(
    .NUM_LAYERS (NL),
    .CW         (CW),
    .FG_LAYER   (1),
    .IO_BASE    (8'h20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vga_h_sync      (hs),
    .vga_v_sync      (vs),
    .in_display_area (disp),
    .counter_y_lsb   (lsb),
    .layer_data      (ldata),
    .layer_active    (lact),
    .foreground_mask (fg),
    .io_in           (io_in),
    .io_address_in   (addr),
    .io_data_in      (data),
    .vga_r           (vr),
    .vga_g           (vg),
    .vga_b           (vb),
    .vga_h_sync_out  (hso),
    .vga_v_sync_out  (vso),
    .vga_de_out      (deo)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } px_t;

  px_t         m_stage, m_out;
  logic [7:0]  m_ctrl, m_len;
  logic [15:0] m_bd;
  logic        m_ack;

  // What the screen must show for the current inputs under the model's register state.
  function automatic px_t model_pixel();
    px_t         p;
    logic [11:0] c;
    bit          found;
    found = 1'b0;
    c = m_bd[11:0];
    for (int i = 0; i < NL; i++) begin
      bit vis;
      vis = lact[i] && m_len[i] && !(i == 1 && fg) && !(i == NL - 1 && !m_ctrl[1]);
      if (vis && !found) begin
        c = ldata[i*12 +: 12];
        found = 1'b1;
      end
    end
    p.de = disp && m_ctrl[7];
    p.hs = hs;
    p.vs = vs;
    if (!p.de) c = 12'h000;
`ifdef VIDEO_MIXER_SCANLINE_EN
    else if (m_ctrl[0] && !lsb)
      c = {c[11:8] >> m_ctrl[3:2], c[7:4] >> m_ctrl[3:2], c[3:0] >> m_ctrl[3:2]};
`endif
    p.rgb = c;
    return p;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_stage <= '0;
      m_out   <= '0;
      m_ctrl  <= 8'h8A;
      m_len   <= 8'hFF;
      m_bd    <= 16'h0000;
      m_ack   <= 1'b0;
    end else begin
      m_out   <= m_stage;
      m_stage <= model_pixel();
      m_ack   <= !io_in;
      if (!io_in && !m_ack) begin
        case (addr[7:0])
          8'h20:   m_ctrl     <= data;
          8'h21:   m_len      <= data;
          8'h22:   m_bd[7:0]  <= data;
          8'h23:   m_bd[15:8] <= data;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pipe_rgb", {20'd0, vr, vg, vb}, {20'd0, m_out.rgb});
      check("pipe_sync_de", {29'd0, hso, vso, deo}, {29'd0, m_out.hs, m_out.vs, m_out.de});
    end
  end

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    data  = d;
    io_in = 1'b0;
    @(negedge clk);
    io_in = 1'b1;
    $display("[TB] write addr %h data %h", a, d);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [11:0] exp);
    check(name, {20'd0, vr, vg, vb}, {20'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; io_in = 1'b1; addr = '0; data = '0;
    hs = 1'b0; vs = 1'b0; disp = 1'b0; lsb = 1'b1; fg = 1'b0;
    lact = '0; ldata = '0;
    repeat (3) @(negedge clk);
    check("reset_out", {16'd0, vr, vg, vb, deo, hso, vso, 1'b0}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    ldata = {12'h00F, 12'h0AA, 12'h0F0, 12'hF00};
    lact  = 4'hF; disp = 1'b1; hs = 1'b1;
    settle();
    lit("t1_priority", 12'hF00);
    check("t1_de", {31'd0, deo}, 32'd1);
    disp = 1'b0;
    settle();
    lit("t1_blank", 12'h000);
    check("t1_de_blank", {31'd0, deo}, 32'd0);
    disp = 1'b1; vs = 1'b1;

    lact = 4'b1000;
    settle();
    lit("t2_bg_on", 12'h00F);
    io_write(16'h0020, 8'h88);
    io_write(16'h0022, 8'h34);
    io_write(16'h0023, 8'h02);
    settle();
    lit("t2_backdrop", 12'h234);

    io_write(16'hAB20, 8'h8A);
    lact = 4'b1010; fg = 1'b1;
    settle();
    lit("t3_fg_masked", 12'h00F);
    fg = 1'b0;
    settle();
    lit("t3_fg_clear", 12'h0F0);

    ldata[11:0] = 12'hFFF;
    lact = 4'b0001;
    io_write(16'h0020, 8'h8B);
    lsb = 1'b0;
    settle();
    lit("t4_dim_even", DIM_EXP);
    lsb = 1'b1;
    settle();
    lit("t4_dim_odd", 12'hFFF);
    io_write(16'h0020, 8'h83);
    lsb = 1'b0;
    settle();
    lit("t4_shift0_even", 12'hFFF);
    lsb = 1'b1;
    settle();
    lit("t4_shift0_odd", 12'hFFF);

    lact = 4'b0000;
    @(negedge clk);
    addr = 16'h0022; data = 8'h11; io_in = 1'b0;
    @(negedge clk);
    data = 8'h55;
    repeat (8) @(negedge clk);
    io_in = 1'b1;
    $display("[TB] long strobe addr 0022 data 11 then 55");
    settle();
    lit("t5_long_strobe", 12'h211);
    io_write(16'h0022, 8'h55);
    settle();
    lit("t5_second_write", 12'h255);

    io_write(16'h0021, 8'h07);
    lact = 4'b1000;
    settle();
    lit("t6_layer_off", 12'h255);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_reset_out", {16'd0, vr, vg, vb, deo, hso, vso, 1'b0}, 32'd0);
    rst_n = 1'b1;
    settle();
    lit("t6_ctrl_reset", 12'h00F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
